// File: rtl/alu_rs_pool.sv
// ALU reservation station pool with an embedded single-stage ALU.
// Holds renamed ALU/branch/jalr ops until both operands are available.
// Issues the oldest ready entry, with age measured as ROB distance from the ROB head.
// The result is held in an output register until the CDB arbiter takes it.
//
// Output handshake: a result transfers on a rising edge where res_valid_out && res_ready_in
// && rdy_in && !flush_in. While res_valid_out is high and res_ready_in is low, every res_*
// output stays unchanged.
module alu_rs_pool #(
  parameter int RS_WIDTH  = 4,
  parameter int ROB_WIDTH = 4,
  parameter int NUM_WB    = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic [ROB_WIDTH-1:0]          rob_head_in,
  input  logic                          disp_valid_in,
  output logic                          disp_ready_out,
  input  logic [ROB_WIDTH-1:0]          disp_rob_in,
  input  logic [6:0]                    disp_op_in,
  input  logic [31:0]                   disp_vj_in,
  input  logic [31:0]                   disp_vk_in,
  input  logic [ROB_WIDTH:0]            disp_qj_in,
  input  logic [ROB_WIDTH:0]            disp_qk_in,
  input  logic [31:0]                   disp_imm_in,
  input  logic [31:0]                   disp_pc_in,
  input  logic [NUM_WB-1:0]             wb_valid_in,
  input  logic [NUM_WB*ROB_WIDTH-1:0]   wb_rob_in,
  input  logic [NUM_WB*32-1:0]          wb_data_in,
  output logic                          res_valid_out,
  input  logic                          res_ready_in,
  output logic [ROB_WIDTH-1:0]          res_rob_out,
  output logic [31:0]                   res_data_out,
  output logic [31:0]                   res_target_out,
  output logic [RS_WIDTH:0]             free_cnt_out,
  output logic                          empty_out,
  output logic                          full_out
);

  localparam int RS_SIZE = 1 << RS_WIDTH;
  localparam logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};
  localparam logic [RS_WIDTH:0]  FULL_CNT = {1'b1, {RS_WIDTH{1'b0}}};

  localparam logic [6:0] OP_JALR  = 7'd4;
  localparam logic [6:0] OP_BEQ   = 7'd5;
  localparam logic [6:0] OP_BNE   = 7'd6;
  localparam logic [6:0] OP_BLT   = 7'd7;
  localparam logic [6:0] OP_BGE   = 7'd8;
  localparam logic [6:0] OP_BLTU  = 7'd9;
  localparam logic [6:0] OP_BGEU  = 7'd10;
  localparam logic [6:0] OP_ADDI  = 7'd19;
  localparam logic [6:0] OP_SLTI  = 7'd20;
  localparam logic [6:0] OP_SLTIU = 7'd21;
  localparam logic [6:0] OP_XORI  = 7'd22;
  localparam logic [6:0] OP_ORI   = 7'd23;
  localparam logic [6:0] OP_ANDI  = 7'd24;
  localparam logic [6:0] OP_SLLI  = 7'd25;
  localparam logic [6:0] OP_SRLI  = 7'd26;
  localparam logic [6:0] OP_SRAI  = 7'd27;
  localparam logic [6:0] OP_ADD   = 7'd28;
  localparam logic [6:0] OP_SUB   = 7'd29;
  localparam logic [6:0] OP_SLL   = 7'd30;
  localparam logic [6:0] OP_SLT   = 7'd31;
  localparam logic [6:0] OP_SLTU  = 7'd32;
  localparam logic [6:0] OP_XOR   = 7'd33;
  localparam logic [6:0] OP_SRL   = 7'd34;
  localparam logic [6:0] OP_SRA   = 7'd35;
  localparam logic [6:0] OP_OR    = 7'd36;
  localparam logic [6:0] OP_AND   = 7'd37;

  // Entry storage
  logic [RS_SIZE-1:0]   r_busy;
  logic [ROB_WIDTH-1:0] r_rob [RS_SIZE];
  logic [6:0]           r_op  [RS_SIZE];
  logic [31:0]          r_vj  [RS_SIZE];
  logic [31:0]          r_vk  [RS_SIZE];
  logic [ROB_WIDTH:0]   r_qj  [RS_SIZE];
  logic [ROB_WIDTH:0]   r_qk  [RS_SIZE];
  logic [31:0]          r_imm [RS_SIZE];
  logic [31:0]          r_pc  [RS_SIZE];

  // Result register and occupancy status
  logic                 r_res_valid;
  logic [ROB_WIDTH-1:0] r_res_rob;
  logic [31:0]          r_res_data;
  logic [31:0]          r_res_target;
  logic [RS_WIDTH:0]    r_free_cnt;
  logic                 r_empty;
  logic                 r_full;

  // Combinational helpers
  logic                 w_self_fire;
  logic [32:0]          w_j_snoop [RS_SIZE];
  logic [32:0]          w_k_snoop [RS_SIZE];
  logic [32:0]          w_dj_snoop;
  logic [32:0]          w_dk_snoop;
  logic [RS_SIZE-1:0]   w_ready;
  logic                 w_found;
  logic [RS_WIDTH-1:0]  w_sel;
  logic [ROB_WIDTH-1:0] w_best_dist;
  logic [ROB_WIDTH-1:0] w_dist;
  logic                 w_issue;
  logic                 w_free_found;
  logic [RS_WIDTH-1:0]  w_alloc_idx;
  logic                 w_alloc;
  logic [RS_WIDTH:0]    w_free_nxt;
  logic [6:0]           w_op;
  logic [31:0]          w_a;
  logic [31:0]          w_b;
  logic [4:0]           w_shamt;
  logic [31:0]          w_alu_data;
  logic [31:0]          w_alu_target;

  // Tag match against the writeback buses and the station's own departing result.
  // The own result wins over any bus; among buses the lowest index wins.
  function automatic logic [32:0] snoop(
    input logic [ROB_WIDTH:0]          tag,
    input logic                        self_fire,
    input logic [ROB_WIDTH-1:0]        self_rob,
    input logic [31:0]                 self_data,
    input logic [NUM_WB-1:0]           wbv,
    input logic [NUM_WB*ROB_WIDTH-1:0] wbr,
    input logic [NUM_WB*32-1:0]        wbd
  );
    logic [32:0] res;
    res = '0;
    for (int b = NUM_WB - 1; b >= 0; b--) begin
      if (wbv[b] && tag == {1'b0, wbr[b*ROB_WIDTH +: ROB_WIDTH]}) res = {1'b1, wbd[b*32 +: 32]};
    end
    if (self_fire && tag == {1'b0, self_rob}) res = {1'b1, self_data};
    return res;
  endfunction

  assign w_self_fire = r_res_valid && res_ready_in;

  // Wakeup matches for every stored entry and for the incoming dispatch
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_j_snoop[i] = snoop(r_qj[i], w_self_fire, r_res_rob, r_res_data, wb_valid_in, wb_rob_in, wb_data_in);
      w_k_snoop[i] = snoop(r_qk[i], w_self_fire, r_res_rob, r_res_data, wb_valid_in, wb_rob_in, wb_data_in);
    end
    w_dj_snoop = snoop(disp_qj_in, w_self_fire, r_res_rob, r_res_data, wb_valid_in, wb_rob_in, wb_data_in);
    w_dk_snoop = snoop(disp_qk_in, w_self_fire, r_res_rob, r_res_data, wb_valid_in, wb_rob_in, wb_data_in);
  end

  // Oldest-ready select; ties on ROB distance go to the lower entry index
  always_comb begin
    w_found     = 1'b0;
    w_sel       = '0;
    w_best_dist = '0;
    w_dist      = '0;
    w_ready     = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == NON_DEP) && (r_qk[i] == NON_DEP);
      w_dist     = r_rob[i] - rob_head_in;
      if (w_ready[i] && (!w_found || w_dist < w_best_dist)) begin
        w_found     = 1'b1;
        w_sel       = i[RS_WIDTH-1:0];
        w_best_dist = w_dist;
      end
    end
  end

  // Lowest free slot for allocation; a slot issued this cycle is still busy here
  always_comb begin
    w_free_found = 1'b0;
    w_alloc_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_alloc_idx  = i[RS_WIDTH-1:0];
      end
    end
  end

  assign disp_ready_out = !r_full;
  assign w_issue = rdy_in && !flush_in && w_found && (!r_res_valid || res_ready_in);
  assign w_alloc = rdy_in && !flush_in && disp_valid_in && !r_full && w_free_found;
  assign w_free_nxt = r_free_cnt + (RS_WIDTH+1)'(w_issue) - (RS_WIDTH+1)'(w_alloc);

  // ALU on the selected entry; immediate forms use imm as the second operand
  always_comb begin
    w_op         = r_op[w_sel];
    w_a          = r_vj[w_sel];
    w_b          = (w_op >= OP_ADDI && w_op <= OP_SRAI) ? r_imm[w_sel] : r_vk[w_sel];
    w_shamt      = w_b[4:0];
    w_alu_data   = '0;
    w_alu_target = '0;
    case (w_op)
      OP_JALR: begin
        w_alu_data   = r_pc[w_sel] + 32'd4;
        w_alu_target = (r_vj[w_sel] + r_imm[w_sel]) & ~32'h1;
      end
      OP_BEQ:  begin w_alu_data = {31'b0, w_a == w_b};                   w_alu_target = r_pc[w_sel] + r_imm[w_sel]; end
      OP_BNE:  begin w_alu_data = {31'b0, w_a != w_b};                   w_alu_target = r_pc[w_sel] + r_imm[w_sel]; end
      OP_BLT:  begin w_alu_data = {31'b0, $signed(w_a) < $signed(w_b)};  w_alu_target = r_pc[w_sel] + r_imm[w_sel]; end
      OP_BGE:  begin w_alu_data = {31'b0, $signed(w_a) >= $signed(w_b)}; w_alu_target = r_pc[w_sel] + r_imm[w_sel]; end
      OP_BLTU: begin w_alu_data = {31'b0, w_a < w_b};                    w_alu_target = r_pc[w_sel] + r_imm[w_sel]; end
      OP_BGEU: begin w_alu_data = {31'b0, w_a >= w_b};                   w_alu_target = r_pc[w_sel] + r_imm[w_sel]; end
      OP_ADDI, OP_ADD:   w_alu_data = w_a + w_b;
      OP_SUB:            w_alu_data = w_a - w_b;
      OP_SLTI, OP_SLT:   w_alu_data = {31'b0, $signed(w_a) < $signed(w_b)};
      OP_SLTIU, OP_SLTU: w_alu_data = {31'b0, w_a < w_b};
      OP_XORI, OP_XOR:   w_alu_data = w_a ^ w_b;
      OP_ORI, OP_OR:     w_alu_data = w_a | w_b;
      OP_ANDI, OP_AND:   w_alu_data = w_a & w_b;
      OP_SLLI, OP_SLL:   w_alu_data = w_a << w_shamt;
      OP_SRLI, OP_SRL:   w_alu_data = w_a >> w_shamt;
      OP_SRAI, OP_SRA:   w_alu_data = $unsigned($signed(w_a) >>> w_shamt);
      default:           w_alu_data = '0;
    endcase
  end

  // Entry state: wakeup, issue release and allocation
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_rob[i] <= '0;
        r_op[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_qj[i]  <= NON_DEP;
        r_qk[i]  <= NON_DEP;
        r_imm[i] <= '0;
        r_pc[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        r_busy <= '0;
        for (int i = 0; i < RS_SIZE; i++) begin
          r_qj[i] <= NON_DEP;
          r_qk[i] <= NON_DEP;
        end
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i]) begin
            if (w_j_snoop[i][32]) begin
              r_qj[i] <= NON_DEP;
              r_vj[i] <= w_j_snoop[i][31:0];
            end
            if (w_k_snoop[i][32]) begin
              r_qk[i] <= NON_DEP;
              r_vk[i] <= w_k_snoop[i][31:0];
            end
          end
        end
        if (w_issue) r_busy[w_sel] <= 1'b0;
        if (w_alloc) begin
          r_busy[w_alloc_idx] <= 1'b1;
          r_rob[w_alloc_idx]  <= disp_rob_in;
          r_op[w_alloc_idx]   <= disp_op_in;
          r_imm[w_alloc_idx]  <= disp_imm_in;
          r_pc[w_alloc_idx]   <= disp_pc_in;
          r_qj[w_alloc_idx]   <= w_dj_snoop[32] ? NON_DEP : disp_qj_in;
          r_vj[w_alloc_idx]   <= w_dj_snoop[32] ? w_dj_snoop[31:0] : disp_vj_in;
          r_qk[w_alloc_idx]   <= w_dk_snoop[32] ? NON_DEP : disp_qk_in;
          r_vk[w_alloc_idx]   <= w_dk_snoop[32] ? w_dk_snoop[31:0] : disp_vk_in;
        end
      end
    end
  end

  // Occupancy counters track the busy bits after each edge
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_free_cnt <= FULL_CNT;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_free_cnt <= FULL_CNT;
        r_empty    <= 1'b1;
        r_full     <= 1'b0;
      end else begin
        r_free_cnt <= w_free_nxt;
        r_empty    <= (w_free_nxt == FULL_CNT);
        r_full     <= (w_free_nxt == '0);
      end
    end
  end

  // Result register: load on issue, drop on acceptance, cleared by flush
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_res_valid  <= 1'b0;
      r_res_rob    <= '0;
      r_res_data   <= '0;
      r_res_target <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_res_valid <= 1'b0;
      end else if (w_issue) begin
        r_res_valid  <= 1'b1;
        r_res_rob    <= r_rob[w_sel];
        r_res_data   <= w_alu_data;
        r_res_target <= w_alu_target;
      end else if (res_ready_in) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid_out  = r_res_valid;
  assign res_rob_out    = r_res_rob;
  assign res_data_out   = r_res_data;
  assign res_target_out = r_res_target;
  assign free_cnt_out   = r_free_cnt;
  assign empty_out      = r_empty;
  assign full_out       = r_full;

endmodule
